// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults), counter type
// and a small range helper used by the sync decoders.
package vga_pkg;

  localparam int unsigned CNT_W = 32'd10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int unsigned DEF_H_VISIBLE = 32'd640;
  localparam int unsigned DEF_H_FP      = 32'd16;
  localparam int unsigned DEF_H_SYNC    = 32'd96;
  localparam int unsigned DEF_H_BP      = 32'd48;
  localparam int unsigned DEF_V_VISIBLE = 32'd480;
  localparam int unsigned DEF_V_FP      = 32'd10;
  localparam int unsigned DEF_V_SYNC    = 32'd2;
  localparam int unsigned DEF_V_BP      = 32'd33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 32'd1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 32'd1;

  // Inclusive unsigned range test on a counter value.
  function automatic logic in_range(input cnt_t value, input cnt_t lo, input cnt_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA DAC/connector bundle: pixel clock, syncs, blanking and colour.
interface vga_timing_gen_if;

  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// Modulo-MODULUS counter with enable. o_wrap flags the enabled cycle in
// which the counter returns from MODULUS-1 to 0, so it can enable the
// next counter in a cascade.
module sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_H_TOTAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output cnt_t o_count,
  output logic o_wrap
);

  localparam cnt_t LAST = cnt_t'(MODULUS - 32'd1);

  cnt_t r_count;
  logic w_term;

  assign w_term  = (r_count == LAST);
  assign o_wrap  = i_en & w_term;
  assign o_count = r_count;

  // Advance modulo MODULUS while enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      if (w_term) begin
        r_count <= {CNT_W{1'b0}};
      end else begin
        r_count <= r_count + 10'd1;
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. VGA_CLK is Clk/2; counters and the output
// stage advance on the Clk edge where VGA_CLK falls, so the DAC samples
// on the following VGA_CLK rise with data stable. Colour/sync/blank are
// one pixel behind DrawX/DrawY and mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       vblank,
  output logic       frame_start,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 32'd1);
  localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 32'd1);

  logic       r_vga_clk;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_frame_start;

  logic       w_pix_en;
  cnt_t       w_hc;
  cnt_t       w_vc;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_visible;
  logic       w_hs_raw;
  logic       w_vs_raw;

  assign w_pix_en = r_vga_clk;

  sync_counter #(.MODULUS(H_TOTAL)) u_hcnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_en    (w_pix_en),
    .o_count (w_hc),
    .o_wrap  (w_h_wrap)
  );

  // Vertical counter steps once per completed line; its wrap marks frame end.
  sync_counter #(.MODULUS(V_TOTAL)) u_vcnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_en    (w_h_wrap),
    .o_count (w_vc),
    .o_wrap  (w_v_wrap)
  );

  assign w_visible = (w_hc < cnt_t'(H_VISIBLE)) && (w_vc < cnt_t'(V_VISIBLE));
  assign w_hs_raw  = ~in_range(w_hc, HS_START, HS_END);
  assign w_vs_raw  = ~in_range(w_vc, VS_START, VS_END);

  // Pixel clock: divide Clk by two; the high phase enables the pixel edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vga_clk <= 1'b0;
    end else begin
      r_vga_clk <= ~r_vga_clk;
    end
  end

  // Output stage: register colour/sync/blank for the current pixel; blank colour outside the visible area.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_red     <= 8'd0;
      r_green   <= 8'd0;
      r_blue    <= 8'd0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_pix_en) begin
      r_red     <= w_visible ? Red_in   : 8'd0;
      r_green   <= w_visible ? Green_in : 8'd0;
      r_blue    <= w_visible ? Blue_in  : 8'd0;
      r_hs      <= w_hs_raw;
      r_vs      <= w_vs_raw;
      r_blank_n <= w_visible;
    end else begin
      r_red     <= r_red;
      r_green   <= r_green;
      r_blue    <= r_blue;
      r_hs      <= r_hs;
      r_vs      <= r_vs;
      r_blank_n <= r_blank_n;
    end
  end

  // Frame start: one Clk pulse right after the counters wrap to (0,0).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_v_wrap;
    end
  end

  assign DrawX       = w_hc;
  assign DrawY       = w_vc;
  assign vblank      = (w_vc >= cnt_t'(V_VISIBLE));
  assign frame_start = r_frame_start;

  assign vga.VGA_CLK     = r_vga_clk;
  assign vga.VGA_HS      = r_hs;
  assign vga.VGA_VS      = r_vs;
  assign vga.VGA_BLANK_N = r_blank_n;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = r_red;
  assign vga.VGA_G       = r_green;
  assign vga.VGA_B       = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-timing instance (A) exercises full
// frames, a default-timing instance (B) exercises real 640x480 lines.
// Expected pixel outputs are pushed to a queue when colours are driven
// and popped when the pixel edge loads them into the DUT.
module tb_vga_timing_gen;

  localparam int AHV = 16, AHF = 4, AHS = 6, AHB = 6;
  localparam int AVV = 6,  AVF = 2, AVS = 2, AVB = 3;
  localparam int AHT = AHV + AHF + AHS + AHB;   // 32
  localparam int AVT = AVV + AVF + AVS + AVB;   // 13
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVV = 480, BVF = 10, BVS = 2,  BVB = 33;
  localparam int BHT = BHV + BHF + BHS + BHB;   // 800
  localparam int BVT = BVV + BVF + BVS + BVB;   // 525

  logic       Clk;
  logic       Reset_n;
  logic [7:0] red, green, blue;
  logic [9:0] dxa, dya, dxb, dyb;
  logic       vba, vbb, fsa, fsb;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen #(
    .H_VISIBLE(AHV), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_VISIBLE(AVV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB)
  ) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(red), .Green_in(green), .Blue_in(blue),
    .DrawX(dxa), .DrawY(dya), .vblank(vba), .frame_start(fsa), .vga(vif_a)
  );

  vga_timing_gen dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Red_in(red), .Green_in(green), .Blue_in(blue),
    .DrawX(dxb), .DrawY(dyb), .vblank(vbb), .frame_start(fsb), .vga(vif_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] r; logic [7:0] g; logic [7:0] b;
    logic hs; logic vs; logic blank_n;
  } pix_t;

  typedef struct packed {
    logic [9:0] hc; logic [9:0] vc; logic vclk; pix_t o; logic fs;
  } mdl_t;

  pix_t qa[$], qb[$];
  mdl_t ma, mb;
  int   n_cmp, n_fail, e_cnt;
  int   hs_falls_b, hs_fall1_b, hs_fall2_b, hs_w1_b;
  int   fs_cnt_a, fs_first_a, fs_last_a, vs_cnt_a, vs_w_a;
  int   max_dx_a, max_dy_a;
  logic prev_hs_b, prev_vs_a;

  function automatic pix_t pixel_out(logic [9:0] hc, logic [9:0] vc, int hv, int hf, int hs,
                                     int vv, int vf, int vs, logic [7:0] r, logic [7:0] g, logic [7:0] b);
    pix_t p;
    logic vis;
    int   h, v;
    h = int'(hc);
    v = int'(vc);
    vis = (h < hv) && (v < vv);
    p.r = vis ? r : 8'h00;
    p.g = vis ? g : 8'h00;
    p.b = vis ? b : 8'h00;
    p.hs = !((h >= hv + hf) && (h < hv + hf + hs));
    p.vs = !((v >= vv + vf) && (v < vv + vf + vs));
    p.blank_n = vis;
    return p;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.o.hs = 1'b1;
    m.o.vs = 1'b1;
    return m;
  endfunction

  function automatic mdl_t mdl_edge(mdl_t m, int ht, int vt, pix_t nxt);
    mdl_t n;
    n = m;
    n.vclk = ~m.vclk;
    n.fs = 1'b0;
    if (m.vclk) begin
      n.o = nxt;
      if (int'(m.hc) == ht - 1) begin
        n.hc = 10'd0;
        if (int'(m.vc) == vt - 1) begin
          n.vc = 10'd0;
          n.fs = 1'b1;
        end else begin
          n.vc = m.vc + 10'd1;
        end
      end else begin
        n.hc = m.hc + 10'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] exp_vec(mdl_t m, int vv);
    logic vb;
    vb = (int'(m.vc) >= vv);
    return {13'd0, m.hc, m.vc, m.vclk, m.o.hs, m.o.vs, m.o.blank_n, 1'b0,
            m.o.r, m.o.g, m.o.b, vb, m.fs};
  endfunction

  function automatic logic [63:0] obs_a();
    return {13'd0, dxa, dya, vif_a.VGA_CLK, vif_a.VGA_HS, vif_a.VGA_VS, vif_a.VGA_BLANK_N,
            vif_a.VGA_SYNC_N, vif_a.VGA_R, vif_a.VGA_G, vif_a.VGA_B, vba, fsa};
  endfunction

  function automatic logic [63:0] obs_b();
    return {13'd0, dxb, dyb, vif_b.VGA_CLK, vif_b.VGA_HS, vif_b.VGA_VS, vif_b.VGA_BLANK_N,
            vif_b.VGA_SYNC_N, vif_b.VGA_R, vif_b.VGA_G, vif_b.VGA_B, vbb, fsb};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clear_meas();
    e_cnt = 0;
    hs_falls_b = 0; hs_fall1_b = -1; hs_fall2_b = -1; hs_w1_b = 0; prev_hs_b = 1'b1;
    fs_cnt_a = 0; fs_first_a = -1; fs_last_a = 0;
    vs_cnt_a = 0; vs_w_a = 0; prev_vs_a = 1'b1;
    max_dx_a = 0; max_dy_a = 0;
  endtask

  // Edge-timed measurements of DUT waveforms, in Clk edges since reset release.
  task automatic monitor();
    if (prev_hs_b && !vif_b.VGA_HS) begin
      hs_falls_b++;
      if (hs_falls_b == 1) hs_fall1_b = e_cnt;
      else if (hs_falls_b == 2) hs_fall2_b = e_cnt;
    end
    if (!vif_b.VGA_HS && hs_falls_b == 1) hs_w1_b++;
    prev_hs_b = vif_b.VGA_HS;
    if (fsa) begin
      fs_cnt_a++;
      if (fs_cnt_a == 1) fs_first_a = e_cnt;
      else check("fs_spacing_a", 64'(e_cnt - fs_last_a), 64'(2 * AHT * AVT));
      fs_last_a = e_cnt;
    end
    if (prev_vs_a && !vif_a.VGA_VS) begin
      vs_cnt_a++;
      vs_w_a = 0;
    end
    if (!vif_a.VGA_VS) vs_w_a++;
    if (!prev_vs_a && vif_a.VGA_VS && vs_cnt_a > 0)
      check("vs_width_a", 64'(vs_w_a), 64'(2 * AVS * AHT));
    prev_vs_a = vif_a.VGA_VS;
    if (int'(dxa) > max_dx_a) max_dx_a = int'(dxa);
    if (int'(dya) > max_dy_a) max_dy_a = int'(dya);
  endtask

  task automatic step();
    pix_t pa, pb;
    if (Reset_n) begin
      if (ma.vclk) qa.push_back(pixel_out(ma.hc, ma.vc, AHV, AHF, AHS, AVV, AVF, AVS, red, green, blue));
      if (mb.vclk) qb.push_back(pixel_out(mb.hc, mb.vc, BHV, BHF, BHS, BVV, BVF, BVS, red, green, blue));
    end
    @(posedge Clk);
    #1;
    if (!Reset_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
      qa.delete();
      qb.delete();
    end else begin
      pa = ma.o;
      pb = mb.o;
      if (ma.vclk && qa.size() > 0) pa = qa.pop_front();
      if (mb.vclk && qb.size() > 0) pb = qb.pop_front();
      ma = mdl_edge(ma, AHT, AVT, pa);
      mb = mdl_edge(mb, BHT, BVT, pb);
      e_cnt++;
      monitor();
    end
    check("cycle_a", obs_a(), exp_vec(ma, AVV));
    check("cycle_b", obs_b(), exp_vec(mb, BVV));
  endtask

  task automatic rand_colour();
    red   = 8'($urandom_range(255, 0));
    green = 8'($urandom_range(255, 0));
    blue  = 8'($urandom_range(255, 0));
  endtask

  task automatic phase_checks(input int n_frames);
    check("hs_first_fall_b", 64'(hs_fall1_b), 64'(2 * (BHV + BHF + 1)));
    check("hs_width_b", 64'(hs_w1_b), 64'(2 * BHS));
    check("hs_second_fall_b", 64'(hs_fall2_b), 64'(2 * (BHV + BHF + 1) + 2 * BHT));
    check("fs_first_a", 64'(fs_first_a), 64'(2 * AHT * AVT));
    check("fs_count_a", 64'(fs_cnt_a), 64'(n_frames));
    check("vs_count_a", 64'(vs_cnt_a), 64'(n_frames));
    check("max_dx_a", 64'(max_dx_a), 64'(AHT - 1));
    check("max_dy_a", 64'(max_dy_a), 64'(AVT - 1));
  endtask

  initial begin
    int guard;
    n_cmp = 0;
    n_fail = 0;
    Reset_n = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    ma = mdl_reset();
    mb = mdl_reset();
    clear_meas();

    // Held in reset: outputs at reset values.
    repeat (3) step();

    // Release between edges; first line with solid red.
    #3 Reset_n = 1'b1;
    clear_meas();
    red = 8'hFF; green = 8'h00; blue = 8'h00;
    for (int i = 0; i < 200; i++) step();

    // Random colours across four short frames and two full-size lines.
    for (int i = 0; i < 3200; i++) begin
      rand_colour();
      step();
    end
    phase_checks(4);

    // Run to mid-frame on A, then reset asynchronously between edges.
    guard = 0;
    while (!(ma.hc == 10'd10 && ma.vc == 10'd4) && guard < 2000) begin
      red = 8'h3F;
      step();
      guard++;
    end
    check("reach_mid_a", {44'd0, ma.vc, ma.hc}, {44'd0, 10'd4, 10'd10});
    #2 Reset_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    qa.delete();
    qb.delete();
    check("async_rst_a", obs_a(), exp_vec(ma, AVV));
    check("async_rst_b", obs_b(), exp_vec(mb, BVV));
    repeat (2) step();

    // Release again: counting restarts cleanly from (0,0).
    #3 Reset_n = 1'b1;
    clear_meas();
    for (int i = 0; i < 3000; i++) begin
      rand_colour();
      step();
    end
    phase_checks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, all in pixels or lines, defaults from vga_pkg.
REQ-002 Port: Clk  in  1  system clock, 50 MHz; one clock domain.
REQ-003 Port: Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: Red_in, Green_in, Blue_in  in  8 each  pixel colour from the colour-mapping stage for the current DrawX/DrawY.
REQ-005 Port: DrawX, DrawY  out  10 each  current pixel column and line counters.
REQ-006 Port: VGA_CLK  out  1  25 MHz pixel clock.
REQ-007 Port: VGA_HS, VGA_VS  out  1 each  syncs, active-low.
REQ-008 Port: VGA_BLANK_N  out  1  low outside the visible area.
REQ-009 Port: VGA_SYNC_N  out  1  tied 0.
REQ-010 Port: VGA_R, VGA_G, VGA_B  out  8 each  registered DAC colour.
REQ-011 Port: vblank  out  1  high while DrawY >= V_VISIBLE.
REQ-012 Port: frame_start  out  1  single-Clk pulse at start of frame.

Function
REQ-013 VGA_CLK SHALL be a register toggling every Clk; pix_en is defined as VGA_CLK==1.
REQ-014 On each Clk edge with pix_en=1, hc SHALL increment; at H_TOTAL-1 (799) it SHALL wrap to 0 and vc SHALL increment.
REQ-015 vc SHALL wrap from V_TOTAL-1 (524) to 0 on the same edge that hc wraps.
REQ-016 Counters SHALL hold when pix_en=0. DrawX=hc and DrawY=vc, driven directly from the counter registers.
REQ-017 visible = (hc<640)&&(vc<480).
REQ-018 hs_raw is low for hc in 656..751; vs_raw is low for vc in 490..491.
REQ-019 Output stage SHALL load on pix_en edges: VGA_R/G/B <= visible ? *_in : 0; VGA_HS <= hs_raw; VGA_VS <= vs_raw; VGA_BLANK_N <= visible.
REQ-020 Colour, sync and blank outputs SHALL have exactly one pixel of latency relative to DrawX/DrawY, with all outputs mutually aligned.
REQ-021 Output registers change on the edge where VGA_CLK falls; the VGA_CLK rising edge falls mid-data, one Clk later.
REQ-022 vblank SHALL be combinational from vc.
REQ-023 frame_start SHALL be registered and high for exactly one Clk, in the Clk immediately after the counters transition to (0,0).
REQ-024 Arithmetic: hc and vc are 10-bit unsigned; there is no overflow because terminal counts are below 1024; comparisons are unsigned.
REQ-025 Red_in/Green_in/Blue_in are ignored (zeros out) during blanking, whatever their value.

Reset
REQ-026 Reset_n low SHALL immediately force hc=0, vc=0, VGA_CLK=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; no partial sync pulse is generated on release.
REQ-028 After release, the first pix_en edge is the second Clk edge, and counting starts from (0,0).
REQ-029 No frame_start pulse SHALL be issued for the frame that begins at reset release; the first pulse follows the first wrap to (0,0).

Structure
REQ-030 vga_pkg SHALL hold the timing constants, the derived H_TOTAL=800 and V_TOTAL=525, and the sync start/end localparams.
REQ-031 One sub-module sync_counter (10-bit modulo-N counter with enable, wrap output) SHALL be instantiated twice, for horizontal and vertical.
REQ-032 The output stage and frame_start logic SHALL reside in the top.
REQ-033 Target size: 150-250 RTL lines.

Verification
REQ-034 Reset release, Red_in=8'hFF -> VGA_CLK period 2 Clk; DrawX steps 0,1,2 every 2 Clk; VGA_R=FF from the pix_en after DrawX=0 until DrawX=640 plus 1 pixel; VGA_BLANK_N drops at the same point.
REQ-035 Run one line -> VGA_HS low for exactly 96 pixels (192 Clk), starting one pixel after DrawX=656; line period 1600 Clk.
REQ-036 Run two frames -> VGA_VS low for exactly 2 lines (3200 Clk) starting at DrawY=490 plus 1 pixel; frame period 840000 Clk; frame_start pulses exactly once per frame, 840000 Clk apart, each one Clk wide.
REQ-037 Drive Red_in=8'h3F constant with DrawY=480..524 -> VGA_R=0 throughout; vblank=1 exactly for DrawY 480..524.
REQ-038 Assert Reset_n low at DrawX=300, DrawY=200 -> all outputs take reset values within the same Clk, asynchronously; after release, DrawX restarts at 0 and the first VGA_HS pulse occurs at DrawX=656 of line 0.
REQ-039 Wrap check -> at (799,524) the next pix_en edge yields (0,0); DrawY never reaches 525; DrawX never reaches 800.
